dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the target end of the core's load/store port. Accepts one
//  request at a time over a valid/ready channel, performs a byte-masked 64-bit word
//  write or a full-word read after a fixed programmable latency, and returns a
//  response over a valid/ready channel. Sits between the core and its backing RAM.
// PARAMETERS
//  DEPTH_LOG2  10              log2 of number of 64-bit words in the array
//  LATENCY     2               cycles from request accept to resp_valid; legal 1..15
//  BASE_ADDR   64'h8000_0000   byte address of word 0
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   asynchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; high only in IDLE
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   64  byte address; bits [2:0] ignored for indexing
//  req_wdata   in   64  store data
//  req_wmask   in   8   byte enables, bit i -> wdata[8i+7:8i]
//  resp_valid  out  1   response present
//  resp_ready  in   1   initiator accepts response
//  resp_rdata  out  64  load data; 0 for stores and errors
//  resp_err    out  1   address out of range
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0,
//    resp_err=0, latency counter=0. Array contents not reset. A request latched but
//    not yet committed is discarded; its write never reaches the array.
//  - States: IDLE -> WAIT -> RESP -> IDLE. One outstanding request maximum.
//  - IDLE: req_ready=1. Accept on req_valid&&req_ready at edge N: latch write, addr,
//    wdata, wmask; counter <= LATENCY-1; go WAIT. Request inputs ignored outside IDLE.
//  - WAIT: counter decrements each edge; at the edge where counter==0 (edge
//    N+LATENCY) commit the access, load resp_rdata/resp_err, set resp_valid, go RESP.
//    LATENCY=1: WAIT lasts one cycle; resp_valid high right after edge N+1.
//  - Range: in-range iff BASE_ADDR <= addr < BASE_ADDR + 8*2^DEPTH_LOG2 (64-bit
//    unsigned compare, no wrap). Index = (addr-BASE_ADDR)[DEPTH_LOG2+2:3].
//  - Store in range: bytes with wmask=1 replaced, others kept; wmask=0 is a legal
//    no-op. resp_rdata=0, resp_err=0.
//  - Load in range: resp_rdata = full word as it stood before the commit edge; err=0.
//  - Out of range: no array change, resp_rdata=0, resp_err=1.
//  - RESP: resp_valid, resp_rdata, resp_err held stable until resp_ready. On
//    handshake at edge M: resp_valid<=0, resp_rdata<=0, resp_err<=0, go IDLE; next
//    accept earliest at edge M+1. req_ready=0 throughout WAIT and RESP.
//  - Read-after-write: a load accepted after a store's response sees the stored data.
// TESTING
//  1. LATENCY=2: store 0x8000_0010, data 64'h1122334455667788, mask 8'hFF accepted at
//     edge N -> resp_valid high after edge N+2, err=0, rdata=0; load same -> 64'h1122334455667788.
//  2. Store 0x8000_0010 data 64'hAAAAAAAAAAAAAAAA mask 8'h0F over test 1 -> load
//     returns 64'h11223344AAAAAAAA; mask 8'h00 store leaves it unchanged.
//  3. resp_ready held low 5 cycles -> resp_valid/rdata/err stable, req_ready=0, a
//     concurrent req_valid is not accepted; handshake -> IDLE next cycle.
//  4. Store to 0x7FFF_FFF8 and load from BASE_ADDR+8*2^DEPTH_LOG2 -> resp_err=1,
//     rdata=0, array unchanged; load from BASE_ADDR+8*(2^DEPTH_LOG2-1) -> err=0.
//  5. Store 0x8000_0000 accepted, rst pulsed mid-WAIT -> outputs at reset values at
//     once, req_ready=1 after release; load 0x8000_0000 returns prior contents.
//  6. LATENCY=1 and LATENCY=15 builds: response exactly 1 / 15 cycles after accept.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, commits it to a
// byte-maskable 64-bit word array after LATENCY cycles and returns a response.
module dmem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [64:0] LIMIT    = {1'b0, BASE_ADDR} + (65'd8 << DEPTH_LOG2);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [63:0]           mem [DEPTH];
  logic [63:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic                  commit;
  logic                  mem_we;
  logic                  unused_off;

  // 65-bit upper bound so a window ending at the top of the address space cannot wrap
  assign in_range   = (addr_q >= BASE_ADDR) && ({1'b0, addr_q} < LIMIT);
  assign off        = addr_q - BASE_ADDR;
  assign idx        = off[DEPTH_LOG2+2:3];
  assign unused_off = ^{off[63:DEPTH_LOG2+3], off[2:0]};
  assign commit     = (state_q == S_WAIT) && (cnt_q == 4'd0);
  // rst gate keeps a request discarded by reset from ever reaching the array
  assign mem_we     = commit && write_q && in_range && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (wmask_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          wmask_d     = req_wmask;
          cnt_d       = CNT_INIT;
          req_ready_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          resp_valid_d = 1'b1;
          resp_err_d   = !in_range;
          // load data is the word as it stood before this edge's store
          resp_rdata_d = (in_range && !write_q) ? mem[idx] : 64'd0;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = 64'd0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      wmask_q      <= 8'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY 2 / 1 / 15 instances, directed steps with a
// word-level memory model and a queue of expected responses.
module tb_dmem_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] LIMIT = 64'h8000_2000;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [63:0] req_addr   [3];
  logic [63:0] req_wdata  [3];
  logic [7:0]  req_wmask  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [63:0] resp_rdata [3];
  logic        resp_err   [3];

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sbq[$];
  logic [63:0] mdl [int];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    dmem_responder #(
      .DEPTH_LOG2(10),
      .LATENCY   (gi == 0 ? 2 : (gi == 1 ? 1 : 15)),
      .BASE_ADDR (64'h8000_0000)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[gi]),
      .req_ready (req_ready[gi]),
      .req_write (req_write[gi]),
      .req_addr  (req_addr[gi]),
      .req_wdata (req_wdata[gi]),
      .req_wmask (req_wmask[gi]),
      .resp_valid(resp_valid[gi]),
      .resp_ready(resp_ready[gi]),
      .resp_rdata(resp_rdata[gi]),
      .resp_err  (resp_err[gi])
    );
  end

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : ((u == 1) ? 1 : 15);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One transaction on unit u; hold>0 stalls resp_ready and offers a competing store.
  task automatic send(input int u, input logic wr, input logic [63:0] a,
                      input logic [63:0] d, input logic [7:0] m, input int hold);
    int          n;
    int          k;
    int          key;
    logic [63:0] off;
    logic [63:0] w;
    exp_t        e;
    req_write[u]  = wr;
    req_addr[u]   = a;
    req_wdata[u]  = d;
    req_wmask[u]  = m;
    req_valid[u]  = 1'b1;
    resp_ready[u] = 1'b0;
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_timeout", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    chk("req_ready_busy", req_ready[u], 64'd0);
    off = a - BASE;
    key = u * 4096 + int'(off[12:3]);
    if (a < BASE || a >= LIMIT) begin
      e = '{64'd0, 1'b1};
    end else if (wr) begin
      w = mdl.exists(key) ? mdl[key] : 64'd0;
      for (int b = 0; b < 8; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
      mdl[key] = w;
      e = '{64'd0, 1'b0};
    end else begin
      e = '{mdl.exists(key) ? mdl[key] : 64'hx, 1'b0};
    end
    sbq.push_back(e);
    k = 0;
    while (resp_valid[u] !== 1'b1 && k < 40) begin
      @(posedge clk); #1; k++;
    end
    chk($sformatf("latency_u%0d", u), 64'(k), 64'(lat_of(u)));
    e = sbq.pop_front();
    chk($sformatf("rdata_%h", a), resp_rdata[u], e.rdata);
    chk($sformatf("err_%h", a), resp_err[u], 64'(e.err));
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        req_write[u] = 1'b1;
        req_addr[u]  = 64'h8000_0020;
        req_wdata[u] = 64'hDEAD_BEEF_DEAD_BEEF;
        req_wmask[u] = 8'hFF;
        req_valid[u] = 1'b1;
      end
      @(posedge clk); #1;
      chk("hold_valid", resp_valid[u], 64'd1);
      chk("hold_rdata", resp_rdata[u], e.rdata);
      chk("hold_err", resp_err[u], 64'(e.err));
      chk("hold_req_ready", req_ready[u], 64'd0);
    end
    resp_ready[u] = 1'b1;
    @(posedge clk); #1;
    resp_ready[u] = 1'b0;
    req_valid[u]  = 1'b0;
    chk("post_hs_valid", resp_valid[u], 64'd0);
    chk("post_hs_rdata", resp_rdata[u], 64'd0);
    chk("post_hs_req_ready", req_ready[u], 64'd1);
    $display("txn u%0d %s addr=%h wdata=%h mask=%h lat=%0d", u, wr ? "ST" : "LD", a, d, m, k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 3; u++) begin
      req_valid[u] = 1'b0; req_write[u] = 1'b0; req_addr[u] = 64'd0;
      req_wdata[u] = 64'd0; req_wmask[u] = 8'd0; resp_ready[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready[0], 64'd1);
    chk("rst_resp_valid", resp_valid[0], 64'd0);
    chk("rst_resp_rdata", resp_rdata[0], 64'd0);
    chk("rst_resp_err", resp_err[0], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // full store, read back, masked merge, empty mask
    send(0, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0);
    send(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 0);
    send(0, 1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0);
    send(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 0);
    send(0, 1'b1, 64'h8000_0010, 64'h5555_5555_5555_5555, 8'h00, 0);
    send(0, 1'b0, 64'h8000_0013, 64'd0, 8'h00, 0);

    // stalled response with a competing request that must be ignored
    send(0, 1'b1, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
    send(0, 1'b1, 64'h8000_0018, 64'h0BAD_F00D_0BAD_F00D, 8'hFF, 5);
    send(0, 1'b0, 64'h8000_0020, 64'd0, 8'h00, 0);
    send(0, 1'b0, 64'h8000_0018, 64'd0, 8'h00, 0);

    // range boundaries; the below-base store aliases the last word if unchecked
    send(0, 1'b1, 64'h8000_1FF8, 64'hCAFE_0000_1111_2222, 8'hFF, 0);
    send(0, 1'b1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    send(0, 1'b0, 64'h8000_2000, 64'd0, 8'h00, 0);
    send(0, 1'b1, 64'h8000_2000, 64'hEEEE_EEEE_EEEE_EEEE, 8'hFF, 0);
    send(0, 1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 0);

    // reset in the middle of a store's wait period
    send(0, 1'b1, 64'h8000_0000, 64'h0F1E_2D3C_4B5A_6978, 8'hFF, 0);
    req_write[0] = 1'b1;
    req_addr[0]  = 64'h8000_0000;
    req_wdata[0] = 64'h9999_9999_9999_9999;
    req_wmask[0] = 8'hFF;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("midwait_req_ready", req_ready[0], 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_req_ready", req_ready[0], 64'd1);
    chk("async_rst_resp_valid", resp_valid[0], 64'd0);
    chk("async_rst_resp_rdata", resp_rdata[0], 64'd0);
    chk("async_rst_resp_err", resp_err[0], 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("after_rst_req_ready", req_ready[0], 64'd1);
    chk("after_rst_no_resp", resp_valid[0], 64'd0);
    $display("txn u0 RST mid-wait store discarded");
    send(0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 0);

    // minimum and maximum latency builds
    send(1, 1'b1, 64'h8000_0008, 64'h1357_9BDF_2468_ACE0, 8'hFF, 0);
    send(1, 1'b0, 64'h8000_0008, 64'd0, 8'h00, 0);
    send(2, 1'b1, 64'h8000_0008, 64'hFEDC_BA98_7654_3210, 8'hF0, 0);
    send(2, 1'b1, 64'h8000_0008, 64'h0000_0000_7654_3210, 8'h0F, 0);
    send(2, 1'b0, 64'h8000_0008, 64'd0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
